// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shared RAM port arbiter for per-core icache/dcache word requests
// Data beats instruction, round-robin per class, dcache blocks held atomically.
module memory_arbiter #(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic                 CLK,
  input  logic                 n_rst,
  input  logic [CPUS-1:0]      iREN,
  input  logic [32*CPUS-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [31:0]          iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [32*CPUS-1:0]   daddr,
  input  logic [32*CPUS-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [31:0]          dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [OW-1:0] LAST_CPU   = OW'(CPUS - 1);
  localparam logic [CW-1:0] LAST_WORD  = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DATA_XFER, INSTR_XFER} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] d_rr_q, d_rr_d;
  logic [OW-1:0] i_rr_q, i_rr_d;
  logic [CPUS-1:0] d_req;

  assign d_req = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  // Walk downward so the requester nearest to ptr is the last (winning) assignment.
  function automatic logic [OW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [OW-1:0] ptr);
    logic [OW-1:0] pick;
    pick = ptr;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % CPUS]) pick = OW'((int'(ptr) + k) % CPUS);
    end
    return pick;
  endfunction

  function automatic logic [OW-1:0] next_cpu(input logic [OW-1:0] c);
    return (c == LAST_CPU) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    d_rr_d   = d_rr_q;
    i_rr_d   = i_rr_q;
    iwait    = '1;
    dwait    = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        if (|d_req) begin
          owner_d = rr_pick(d_req, d_rr_q);
          cnt_d   = '0;
          state_d = DATA_XFER;
        end else if (|iREN) begin
          owner_d = rr_pick(iREN, i_rr_q);
          cnt_d   = '0;
          state_d = INSTR_XFER;
        end
      end
      DATA_XFER: begin
        ramaddr  = daddr[32*owner_q +: 32];
        ramstore = dstore[32*owner_q +: 32];
        ramWEN   = dWEN[owner_q];
        ramREN   = dREN[owner_q] & ~dWEN[owner_q];
        if (!d_req[owner_q]) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait[owner_q] = 1'b0;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = IDLE;
            d_rr_d  = next_cpu(owner_q);
          end
        end
      end
      INSTR_XFER: begin
        ramaddr = iaddr[32*owner_q +: 32];
        ramREN  = iREN[owner_q];
        if (!iREN[owner_q]) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait[owner_q] = 1'b0;
          i_rr_d         = next_cpu(owner_q);
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      d_rr_q  <= '0;
      i_rr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      d_rr_q  <= d_rr_d;
      i_rr_q  <= i_rr_d;
    end
  end

endmodule
